// File: rtl/wb_commit_queue_if.sv
// Bus bundle for wb_commit_queue: producer handshakes, drain control,
// register-file write port, occupancy and bypass lookup.
interface wb_commit_queue_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;

  logic              hold;
  logic              flush;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [CW-1:0]     wb_count;

  logic [ADDR_W-1:0] byp_addr1;
  logic [ADDR_W-1:0] byp_addr2;
  logic              byp_hit1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data1;
  logic [DATA_W-1:0] byp_data2;

  // Upstream side: drives results, drain control and bypass lookups.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output hold, flush,
    output byp_addr1, byp_addr2,
    input  alu_ready, ld_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  wb_count,
    input  byp_hit1, byp_hit2, byp_data1, byp_data2
  );

  // Queue side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  hold, flush,
    input  byp_addr1, byp_addr2,
    output alu_ready, ld_ready,
    output rf_we, rf_waddr, rf_wdata,
    output wb_count,
    output byp_hit1, byp_hit2, byp_data1, byp_data2
  );
endinterface

// File: rtl/wb_commit_queue.sv
// wb_commit_queue: in-order writeback queue in front of the register file.
// Accepts one result per cycle (load path wins over ALU path), drains one
// entry per cycle onto a registered register-file write port.
// Optional feature macro: WB_BYPASS_EN enables the youngest-first bypass
// search; without it the bypass outputs are tied to zero.
module wb_commit_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input logic            clk,
  input logic            rst_n,
  wb_commit_queue_if.slave wb_if
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] entryRd_q   [DEPTH];
  logic [DATA_W-1:0] entryData_q [DEPTH];

  logic [PW-1:0]     wrPtr_q, wrPtr_d;
  logic [PW-1:0]     rdPtr_q, rdPtr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              rfWe_q, rfWe_d;
  logic [ADDR_W-1:0] rfWaddr_q, rfWaddr_d;
  logic [DATA_W-1:0] rfWdata_q, rfWdata_d;

  logic              full;
  logic              ldReady;
  logic              aluReady;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] pushRd;
  logic [DATA_W-1:0] pushData;

  // Acceptance and drain decisions, all derived from the pre-edge count so a
  // full queue refuses a push even when it drains in the same cycle.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    ldReady  = !full;
    aluReady = !full && !wb_if.ld_valid;
    push     = !wb_if.flush &&
               ((wb_if.ld_valid && ldReady) || (wb_if.alu_valid && aluReady));
    pushRd   = wb_if.ld_valid ? wb_if.ld_rd   : wb_if.alu_rd;
    pushData = wb_if.ld_valid ? wb_if.ld_data : wb_if.alu_data;
    pop      = (count_q != '0) && !wb_if.hold && !wb_if.flush;
  end

  // Next-state for pointers, occupancy and the register-file write port.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    rfWe_d    = 1'b0;
    rfWaddr_d = rfWaddr_q;
    rfWdata_d = rfWdata_q;
    if (wb_if.flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_d   = rdPtr_q + PW'(1);
        rfWe_d    = 1'b1;
        rfWaddr_d = entryRd_q[rdPtr_q];
        rfWdata_d = entryData_q[rdPtr_q];
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state and registered write port; reset discards everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      rfWe_q    <= 1'b0;
      rfWaddr_q <= '0;
      rfWdata_q <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      rfWe_q    <= rfWe_d;
      rfWaddr_q <= rfWaddr_d;
      rfWdata_q <= rfWdata_d;
    end
  end

  // Entry storage; contents only matter while covered by count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      entryRd_q[wrPtr_q]   <= pushRd;
      entryData_q[wrPtr_q] <= pushData;
    end
  end

  assign wb_if.ld_ready  = ldReady;
  assign wb_if.alu_ready = aluReady;
  assign wb_if.rf_we     = rfWe_q;
  assign wb_if.rf_waddr  = rfWaddr_q;
  assign wb_if.rf_wdata  = rfWdata_q;
  assign wb_if.wb_count  = count_q;

`ifdef WB_BYPASS_EN
  // Returns {hit, data}: the write-port register is lowest priority, then
  // queue entries from oldest to youngest so the youngest match wins.
  function automatic logic [DATA_W:0] bypLookup(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0] res;
    logic [PW-1:0]   idx;
    res = '0;
    if (rfWe_q && (rfWaddr_q == addr)) begin
      res = {1'b1, rfWdata_q};
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr_q + PW'(i);
      if ((CW'(i) < count_q) && (entryRd_q[idx] == addr)) begin
        res = {1'b1, entryData_q[idx]};
      end
    end
    return res;
  endfunction

  logic [DATA_W:0] byp1, byp2;

  // Two independent lookup ports for operand fetch.
  always_comb begin
    byp1 = bypLookup(wb_if.byp_addr1);
    byp2 = bypLookup(wb_if.byp_addr2);
  end

  assign wb_if.byp_hit1  = byp1[DATA_W];
  assign wb_if.byp_data1 = byp1[DATA_W-1:0];
  assign wb_if.byp_hit2  = byp2[DATA_W];
  assign wb_if.byp_data2 = byp2[DATA_W-1:0];
`else
  logic unused_bypAddr;
  assign unused_bypAddr  = ^{wb_if.byp_addr1, wb_if.byp_addr2};
  assign wb_if.byp_hit1  = 1'b0;
  assign wb_if.byp_data1 = '0;
  assign wb_if.byp_hit2  = 1'b0;
  assign wb_if.byp_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Scoreboard bench for wb_commit_queue: a queue-based reference model
// predicts every commit, a negedge monitor checks the register-file port and
// occupancy, and the driver checks ready and bypass outputs.
module tb_wb_commit_queue;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int bad   = 0;

  entry_t mQ[$];
  entry_t expQ[$];
  logic              mRfWe   = 1'b0;
  logic [ADDR_W-1:0] mRfAddr = '0;
  logic [DATA_W-1:0] mRfData = '0;

  wb_commit_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  wb_commit_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wb_if(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of pending results updated at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mQ.delete();
      expQ.delete();
      mRfWe   = 1'b0;
      mRfAddr = '0;
      mRfData = '0;
    end else begin
      automatic bit wasFull = (mQ.size() == DEPTH);
      automatic entry_t e;
      if (bus.flush) begin
        mQ.delete();
        mRfWe = 1'b0;
      end else begin
        if (mQ.size() > 0 && !bus.hold) begin
          e = mQ.pop_front();
          mRfWe   = 1'b1;
          mRfAddr = e.addr;
          mRfData = e.data;
          expQ.push_back(e);
        end else begin
          mRfWe = 1'b0;
        end
        if (!wasFull && bus.ld_valid) begin
          e.addr = bus.ld_rd; e.data = bus.ld_data; mQ.push_back(e);
        end else if (!wasFull && bus.alu_valid) begin
          e.addr = bus.alu_rd; e.data = bus.alu_data; mQ.push_back(e);
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a commit.
  always @(negedge clk) begin
    automatic entry_t e;
    check("wb_count", 32'(bus.wb_count), 32'(mQ.size()));
    check("rf_we", 32'(bus.rf_we), 32'(mRfWe));
    if (bus.rf_we === 1'b1) begin
      if (expQ.size() == 0) begin
        check("unexpected_commit", 32'(1), 32'(0));
      end else begin
        e = expQ.pop_front();
        check("rf_waddr", 32'(bus.rf_waddr), 32'(e.addr));
        check("rf_wdata", 32'(bus.rf_wdata), 32'(e.data));
      end
    end
  end

  // Bypass expectation: youngest pending entry, then the committing value.
  task automatic modelBypass(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WB_BYPASS_EN
    for (int i = mQ.size() - 1; i >= 0; i--) begin
      if (!hit && mQ[i].addr == a) begin
        hit = 1'b1;
        d   = mQ[i].data;
      end
    end
    if (!hit && mRfWe && mRfAddr == a) begin
      hit = 1'b1;
      d   = mRfData;
    end
`endif
  endtask

  task automatic checkOutput();
    logic h;
    logic [DATA_W-1:0] d;
    automatic bit full = (mQ.size() == DEPTH);
    check("ld_ready", 32'(bus.ld_ready), 32'(!full));
    check("alu_ready", 32'(bus.alu_ready), 32'(!full && !bus.ld_valid));
    modelBypass(bus.byp_addr1, h, d);
    check("byp_hit1", 32'(bus.byp_hit1), 32'(h));
    check("byp_data1", 32'(bus.byp_data1), 32'(d));
    modelBypass(bus.byp_addr2, h, d);
    check("byp_hit2", 32'(bus.byp_hit2), 32'(h));
    check("byp_data2", 32'(bus.byp_data2), 32'(d));
  endtask

  task automatic applyStimulus(
    input logic ldV, input logic [ADDR_W-1:0] ldRd, input logic [DATA_W-1:0] ldD,
    input logic aluV, input logic [ADDR_W-1:0] aluRd, input logic [DATA_W-1:0] aluD,
    input logic hld, input logic fl,
    input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    @(negedge clk);
    #1;
    bus.ld_valid  = ldV;  bus.ld_rd  = ldRd;  bus.ld_data  = ldD;
    bus.alu_valid = aluV; bus.alu_rd = aluRd; bus.alu_data = aluD;
    bus.hold = hld; bus.flush = fl;
    bus.byp_addr1 = a1; bus.byp_addr2 = a2;
    #1;
    checkOutput();
  endtask

  task automatic idle(input logic hld, input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, hld, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    bus.ld_valid = 0; bus.alu_valid = 0; bus.flush = 0; bus.hold = 0;
    rst_n = 1'b0;
    #1;
    check("reset_count", 32'(bus.wb_count), 32'(0));
    check("reset_rf_we", 32'(bus.rf_we), 32'(0));
    check("reset_alu_ready", 32'(bus.alu_ready), 32'(1));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.hold = 0; bus.flush = 0; bus.byp_addr1 = 0; bus.byp_addr2 = 0;
    #12;
    check("init_rf_waddr", 32'(bus.rf_waddr), 32'(0));
    check("init_rf_wdata", 32'(bus.rf_wdata), 32'(0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Three entries held in the queue, then reset discards them.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 3'(i + 1), 16'(16'h100 + i), 1, 0, 0, 0);
    doReset();

    // Single ALU result commits one cycle after acceptance.
    applyStimulus(0, 0, 0, 1, 3, 16'h1234, 0, 0, 3, 0);
    idle(0, 3);

    // Load and ALU offered together: load first, ALU next cycle.
    applyStimulus(1, 5, 16'hAAAA, 1, 2, 16'h5555, 0, 0, 5, 2);
    applyStimulus(0, 0, 0, 1, 2, 16'h5555, 0, 0, 5, 2);
    idle(0, 3);

    // Fill while held, fifth offer stalls, release, then wrap pointers.
    for (int i = 0; i < 5; i++) applyStimulus(1, 3'(i), 16'(16'hC000 + i), 0, 0, 0, 1, 0, 3'(i), 3'(7 - i));
    check("held_full_count", 32'(bus.wb_count), 32'(DEPTH));
    idle(0, 6);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 3'(i + 2), 16'(16'hD000 + i), 0, 0, 3'(i), 1);
    idle(0, 3);

    // Youngest pending value wins the bypass search.
    applyStimulus(0, 0, 0, 1, 4, 16'h0001, 1, 0, 4, 6);
    applyStimulus(0, 0, 0, 1, 4, 16'h0002, 1, 0, 4, 6);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 4, 6);
    idle(0, 4);

    // Flush with two queued plus a same-cycle ALU offer.
    applyStimulus(0, 0, 0, 1, 1, 16'hBEE1, 1, 0, 1, 7);
    applyStimulus(0, 0, 0, 1, 7, 16'hBEE7, 1, 0, 1, 7);
    applyStimulus(0, 0, 0, 1, 6, 16'hBEE6, 0, 1, 6, 7);
    idle(0, 3);

    // Randomized traffic with occasional hold, flush and reset.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 2) == 0, 3'($urandom), 16'($urandom),
                      $urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom),
                      $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0,
                      3'($urandom), 3'($urandom));
      end
    end

    idle(0, DEPTH + 3);
    check("final_drained", 32'(expQ.size()), 32'(0));
    check("final_count", 32'(bus.wb_count), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
